mor1kx_rf_wrport_ctrl: RTL and testbench
========================================

# mor1kx_rf_wrport_ctrl

Write-port controller for the cappuccino register file RAMs. It shares the single RF write port (rfa/rfb/rfspr RAMs all take the same wrad/wren/wrda) between three sources: pipeline writeback, debug-unit GPR writes arriving over the SPR bus, and a post-reset clear sequencer that zeroes every GPR. It sits between the writeback stage, the SPR bus and the RF RAM instances, and raises stall requests toward the control unit when it needs the port.

## Interface
Parameters:
- OPTION_RF_ADDR_WIDTH, 5, GPR address width
- OPTION_RF_WORDS, 32, number of GPRs cleared by the sequencer
- OPTION_OPERAND_WIDTH, 32, data width
- OPTION_RF_CLEAR_ON_INIT, "ENABLED", "ENABLED" runs the clear sequence after reset; any other value skips it
- FEATURE_R0_PROTECT, "NONE", "ENABLED" suppresses pipeline and debug writes to r0
- OPTION_STARVE_LIMIT, 4, blocked cycles before stall request (0..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_rf_wb_i  in  1  pipeline writeback strobe
- wb_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  pipeline write address
- result_i  in  OPTION_OPERAND_WIDTH  pipeline write data
- spr_gpr_we_i  in  1  debug GPR write request, level, held until ack
- spr_gpr_adr_i  in  OPTION_RF_ADDR_WIDTH  debug write address
- spr_gpr_dat_i  in  OPTION_OPERAND_WIDTH  debug write data
- spr_gpr_ack_o  out  1  one-cycle registered ack for a debug write
- rf_wren_o  out  1  RF write enable
- rf_wrad_o  out  OPTION_RF_ADDR_WIDTH  RF write address
- rf_wrda_o  out  OPTION_OPERAND_WIDTH  RF write data
- init_busy_o  out  1  clear sequence active; pipeline must not advance
- rf_stall_o  out  1  request to the control unit to hold padv
- rf_dbg_wr_o  out  1  strobe: a debug write is on the port this cycle (control unit flushes bypass state)

## Operation
- States: CLEAR, RUN. Reset enters CLEAR if OPTION_RF_CLEAR_ON_INIT=="ENABLED", else RUN. Reset clears clr_cnt, pending, wait_cnt, ack.
- While rst is high: rf_wren_o=0, spr_gpr_ack_o=0, rf_stall_o=0, rf_dbg_wr_o=0, init_busy_o=1 when clear is enabled (else 0).
- CLEAR: each cycle rf_wren_o=1, rf_wrad_o=clr_cnt, rf_wrda_o=0, clr_cnt++. After the write at OPTION_RF_WORDS-1 the next state is RUN. The sequencer writes r0 regardless of R0_PROTECT. wb_rf_wb_i is ignored in CLEAR.
- Debug capture: when spr_gpr_we_i & !pending & !spr_gpr_ack_o, latch adr/dat into a one-entry buffer and set pending. Capture is allowed in any state.
- Arbitration in RUN: the pipeline has absolute priority. If wb_rf_wb_i, the port carries the pipeline write. Otherwise, if pending, the port carries the buffered write (the commit cycle), rf_dbg_wr_o=1, pending clears at the clock edge, and spr_gpr_ack_o=1 in the following cycle.
- R0 protect enabled: an address-0 write from the pipeline or debug forces rf_wren_o=0. The debug write still commits, acks and pulses rf_dbg_wr_o.
- Starvation: wait_cnt increments each RUN cycle in which pending & wb_rf_wb_i, and saturates at 255. rf_stall_o = pending & (wait_cnt >= OPTION_STARVE_LIMIT), so a limit of 0 stalls immediately. wait_cnt clears on commit.
- The write data/address outputs are combinational muxes of the state, pending and wb inputs. With rf_wren_o=0 their values are don't-care but must be stable (drive the pipeline inputs).

## Timing
- Clear: init_busy_o is high for exactly OPTION_RF_WORDS cycles after rst deasserts (32 by default) and falls in the first RUN cycle.
- Minimum debug latency: we_i first high in cycle 0; capture at the end of 0; commit in cycle 1; ack in cycle 2. A request drops we_i at the end of the ack cycle. No recapture in the ack cycle.
- A pipeline write coincident with commit eligibility defers the commit by one cycle per wb cycle. There is no loss and no reordering.
- rf_stall_o drops in the cycle after commit.
- rst mid-clear restarts at address 0. rst with pending discards the buffer and gives no ack; the requester reissues.
- Debug requests during CLEAR are captured but commit no earlier than the first RUN cycle.

## Test plan
- Reset, defaults: addresses 0..31 are written with 0 on consecutive cycles; init_busy_o is high for 32 cycles; an RF readback is all zeros.
- Idle RUN, debug write r5=0xDEADBEEF: commit in cycle 1 with rf_dbg_wr_o=1 and ack in cycle 2; a read of r5 returns 0xDEADBEEF.
- Debug write r7=0x1234 while wb_rf_wb_i holds for 10 cycles (STARVE_LIMIT=4): rf_stall_o rises after 4 blocked cycles. The commit follows the first wb-free cycle, then ack; rf_stall_o falls the cycle after commit.
- Same-cycle pipeline write r3=0xA and debug write r4=0xB: the pipeline wins, debug commits next cycle, and both values read back.
- R0_PROTECT="ENABLED": pipeline write r0=0x55 and debug write r0=0x66 give rf_wren_o=0 for both, the debug ack is still given, and r0 reads 0.
- Debug request issued during CLEAR, then rst asserted at clr_cnt=10: no ack; the sequence restarts at address 0 and init_busy_o stays high 32 cycles after release.

Source files
------------

// File: rtl/mor1kx_rf_wrport_ctrl.sv
// Shares the single RF write port between the post-reset clear sequencer, pipeline writeback and debug GPR writes.
// Port outputs are combinational; a debug write commits >=1 cycle after capture, ack one cycle after commit.
module mor1kx_rf_wrport_ctrl #(
   parameter OPTION_RF_ADDR_WIDTH    = 5,
   parameter OPTION_RF_WORDS         = 32,
   parameter OPTION_OPERAND_WIDTH    = 32,
   parameter OPTION_RF_CLEAR_ON_INIT = "ENABLED",
   parameter FEATURE_R0_PROTECT      = "NONE",
   parameter OPTION_STARVE_LIMIT     = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wb_rf_wb_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
   input  logic                            spr_gpr_we_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] spr_gpr_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i,
   output logic                            spr_gpr_ack_o,
   output logic                            rf_wren_o,
   output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wrad_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrda_o,
   output logic                            init_busy_o,
   output logic                            rf_stall_o,
   output logic                            rf_dbg_wr_o
);
   localparam int AW = OPTION_RF_ADDR_WIDTH;
   localparam int DW = OPTION_OPERAND_WIDTH;
   localparam bit CLEAR_EN = (OPTION_RF_CLEAR_ON_INIT == "ENABLED");
   localparam bit R0_PROT  = (FEATURE_R0_PROTECT == "ENABLED");
   localparam logic [AW-1:0] LAST_ADR   = AW'(OPTION_RF_WORDS - 1);
   localparam logic [7:0]    STARVE_LIM = 8'(OPTION_STARVE_LIMIT);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic          pending_q, pending_d;
   logic [7:0]    wait_cnt_q, wait_cnt_d;
   logic          ack_q, ack_d;
   logic [AW-1:0] buf_adr_q, buf_adr_d;
   logic [DW-1:0] buf_dat_q, buf_dat_d;

   logic          run, capture, commit;
   logic          port_wren;
   logic [AW-1:0] port_adr;
   logic [DW-1:0] port_dat;

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      pending_d  = pending_q;
      wait_cnt_d = wait_cnt_q;
      buf_adr_d  = buf_adr_q;
      buf_dat_d  = buf_dat_q;

      run     = (state_q == ST_RUN);
      // No recapture while the previous request's ack is still on the bus.
      capture = spr_gpr_we_i & ~pending_q & ~ack_q;
      commit  = run & ~wb_rf_wb_i & pending_q;
      ack_d   = commit;

      if (!run) begin
         clr_cnt_d = clr_cnt_q + AW'(1);
         if (clr_cnt_q == LAST_ADR)
            state_d = ST_RUN;
      end

      if (capture) begin
         pending_d = 1'b1;
         buf_adr_d = spr_gpr_adr_i;
         buf_dat_d = spr_gpr_dat_i;
      end

      if (commit) begin
         pending_d  = 1'b0;
         wait_cnt_d = 8'd0;
      end else if (run && pending_q && wb_rf_wb_i && wait_cnt_q != 8'hff) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      // Pipeline always wins the port; the debug buffer only fills idle cycles.
      if (!run) begin
         port_wren = 1'b1;
         port_adr  = clr_cnt_q;
         port_dat  = '0;
      end else if (!wb_rf_wb_i && pending_q) begin
         port_wren = !(R0_PROT && buf_adr_q == '0);
         port_adr  = buf_adr_q;
         port_dat  = buf_dat_q;
      end else begin
         port_wren = wb_rf_wb_i && !(R0_PROT && wb_rfd_adr_i == '0);
         port_adr  = wb_rfd_adr_i;
         port_dat  = result_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR_EN ? ST_CLEAR : ST_RUN;
         clr_cnt_q  <= '0;
         pending_q  <= 1'b0;
         wait_cnt_q <= 8'd0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         pending_q  <= pending_d;
         wait_cnt_q <= wait_cnt_d;
         ack_q      <= ack_d;
      end
      buf_adr_q <= buf_adr_d;
      buf_dat_q <= buf_dat_d;
   end

   assign rf_wren_o     = ~rst & port_wren;
   assign rf_wrad_o     = port_adr;
   assign rf_wrda_o     = port_dat;
   assign spr_gpr_ack_o = ~rst & ack_q;
   assign rf_dbg_wr_o   = ~rst & commit;
   assign rf_stall_o    = ~rst & pending_q & (wait_cnt_q >= STARVE_LIM);
   assign init_busy_o   = rst ? CLEAR_EN : ~run;

endmodule

// File: tb/tb_mor1kx_rf_wrport_ctrl.sv
// Bench for mor1kx_rf_wrport_ctrl: default and r0-protected instances on shared stimulus, checked per cycle
// against a queue-based model of the port arbitration and an emulated RF RAM per instance.
module tb_mor1kx_rf_wrport_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb = 1'b0;
   logic [4:0]  wb_adr = '0;
   logic [31:0] result = '0;
   logic        we = 1'b0;
   logic [4:0]  dadr = '0;
   logic [31:0] ddat = '0;

   logic        a_ack, a_wren, a_busy, a_stall, a_dbg;
   logic [4:0]  a_wrad;
   logic [31:0] a_wrda;
   logic        p_ack, p_wren, p_busy, p_stall, p_dbg;
   logic [4:0]  p_wrad;
   logic [31:0] p_wrda;

   always #5 clk = ~clk;

   mor1kx_rf_wrport_ctrl dut_a (
      .clk(clk), .rst(rst), .wb_rf_wb_i(wb), .wb_rfd_adr_i(wb_adr), .result_i(result),
      .spr_gpr_we_i(we), .spr_gpr_adr_i(dadr), .spr_gpr_dat_i(ddat), .spr_gpr_ack_o(a_ack),
      .rf_wren_o(a_wren), .rf_wrad_o(a_wrad), .rf_wrda_o(a_wrda), .init_busy_o(a_busy),
      .rf_stall_o(a_stall), .rf_dbg_wr_o(a_dbg));

   mor1kx_rf_wrport_ctrl #(.FEATURE_R0_PROTECT("ENABLED")) dut_p (
      .clk(clk), .rst(rst), .wb_rf_wb_i(wb), .wb_rfd_adr_i(wb_adr), .result_i(result),
      .spr_gpr_we_i(we), .spr_gpr_adr_i(dadr), .spr_gpr_dat_i(ddat), .spr_gpr_ack_o(p_ack),
      .rf_wren_o(p_wren), .rf_wrad_o(p_wrad), .rf_wrda_o(p_wrda), .init_busy_o(p_busy),
      .rf_stall_o(p_stall), .rf_dbg_wr_o(p_dbg));

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } dw_t;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] ram [2][32];
   logic [31:0] mem [2][32];
   int          clr_left = 32;
   dw_t         q[$];
   int          blocked  = 0;
   bit          ack_next = 0;
   bit          req_on   = 0;
   logic [4:0]  req_adr  = '0;
   logic [31:0] req_dat  = '0;
   int          busy_cnt = 0;
   bit          stall_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic dbg_req(input logic [4:0] a, input logic [31:0] d);
      req_on  = 1'b1;
      req_adr = a;
      req_dat = d;
   endtask

   task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd);
      bit          run, commit, capture, ew, eack;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        o_wren, o_ack, o_dbg, o_stall, o_busy;
      logic [4:0]  o_wrad;
      logic [31:0] o_wrda;
      @(negedge clk);
      rst = r; wb = w; wb_adr = wa; result = wd;
      we = req_on; dadr = req_adr; ddat = req_dat;
      #1;
      run    = (clr_left == 0);
      commit = !r && run && !w && q.size() > 0;
      eack   = !r && ack_next;
      for (int p = 0; p < 2; p++) begin
         ea = '0; ed = '0; ew = 0;
         if (r) ew = 0;
         else if (!run) begin ew = 1; ea = 5'(32 - clr_left); ed = '0; end
         else if (w) begin ew = !(p == 1 && wa == 0); ea = wa; ed = wd; end
         else if (q.size() > 0) begin ew = !(p == 1 && q[0].a == 0); ea = q[0].a; ed = q[0].d; end
         o_wren  = p ? p_wren  : a_wren;
         o_wrad  = p ? p_wrad  : a_wrad;
         o_wrda  = p ? p_wrda  : a_wrda;
         o_ack   = p ? p_ack   : a_ack;
         o_dbg   = p ? p_dbg   : a_dbg;
         o_stall = p ? p_stall : a_stall;
         o_busy  = p ? p_busy  : a_busy;
         chk(p ? "p_wren" : "a_wren", o_wren, ew);
         if (ew) begin
            chk(p ? "p_wrad" : "a_wrad", o_wrad, ea);
            chk(p ? "p_wrda" : "a_wrda", o_wrda, ed);
            mem[p][ea] = ed;
         end
         chk(p ? "p_ack" : "a_ack", o_ack, eack);
         chk(p ? "p_dbg_wr" : "a_dbg_wr", o_dbg, commit);
         chk(p ? "p_stall" : "a_stall", o_stall, !r && q.size() > 0 && blocked >= 4);
         chk(p ? "p_busy" : "a_busy", o_busy, r ? 1'b1 : !run);
         if (o_wren === 1'b1) ram[p][o_wrad] = o_wrda;
      end
      if (!r && a_busy === 1'b1) busy_cnt++;
      if (a_stall === 1'b1) stall_seen = 1;
      if (r) begin
         clr_left = 32; q.delete(); blocked = 0; ack_next = 0;
      end else begin
         capture = req_on && q.size() == 0 && !eack;
         if (commit) begin
            void'(q.pop_front());
            blocked = 0;
         end else if (run && q.size() > 0 && w && blocked < 255) begin
            blocked++;
         end
         ack_next = commit;
         if (capture) q.push_back('{a: req_adr, d: req_dat});
         if (!run) clr_left--;
         if (eack) req_on = 0;
      end
   endtask

   initial begin
      repeat (3) step(1, 0, 0, 0);
      busy_cnt = 0;
      repeat (34) step(0, 0, 0, 0);
      chk("clear_len", busy_cnt, 32);
      for (int i = 0; i < 32; i++) chk("rf_clear", ram[0][i], 32'h0);

      dbg_req(5'd5, 32'hDEADBEEF);
      repeat (4) step(0, 0, 0, 0);
      chk("r5_read", ram[0][5], 32'hDEADBEEF);

      dbg_req(5'd7, 32'h1234);
      stall_seen = 0;
      for (int i = 0; i < 10; i++) step(0, 1, 5'(16 + i), $urandom);
      repeat (4) step(0, 0, 0, 0);
      chk("starve_stall", stall_seen, 1);
      chk("r7_read", ram[0][7], 32'h1234);

      dbg_req(5'd4, 32'hB);
      step(0, 1, 5'd3, 32'hA);
      repeat (3) step(0, 0, 0, 0);
      chk("r3_read", ram[0][3], 32'hA);
      chk("r4_read", ram[0][4], 32'hB);

      step(0, 1, 5'd0, 32'h55);
      dbg_req(5'd0, 32'h66);
      repeat (4) step(0, 0, 0, 0);
      chk("r0_prot", ram[1][0], 32'h0);
      chk("r0_noprot", ram[0][0], 32'h66);

      for (int i = 0; i < 500; i++) begin
         if (!req_on && $urandom_range(3) == 0) dbg_req(5'($urandom), $urandom);
         step($urandom_range(199) == 0, $urandom_range(9) < 6, 5'($urandom), $urandom);
      end

      req_on = 0;
      repeat (2) step(1, 0, 0, 0);
      dbg_req(5'd9, 32'hCAFE);
      repeat (10) step(0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      busy_cnt = 0;
      repeat (36) step(0, 0, 0, 0);
      chk("reclear_len", busy_cnt, 32);
      chk("r9_read", ram[0][9], 32'hCAFE);

      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 32; i++)
            chk(p ? "p_final_rf" : "a_final_rf", ram[p][i], mem[p][i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
